// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: INT entry / RTI return sequencer that drains the pipe and pushes/pops PC and flags over the 16-bit stack port.
module interrupt_sequencer #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0002,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        RTI_Req,
  input  logic        Taken_Jump,
  input  logic [31:0] PC_In,
  input  logic [2:0]  Flags_In,
  input  logic [15:0] Mem_Data_In,
  output logic        Stall,
  output logic        Flush,
  output logic        Mem_Write,
  output logic        Mem_Read,
  output logic [15:0] Mem_Data_Out,
  output logic        PC_Load,
  output logic [31:0] PC_Out,
  output logic        Flags_Load,
  output logic [2:0]  Flags_Out,
  output logic        INT_Ack,
  output logic        Busy
);
  localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  typedef enum logic [3:0] {
    IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, LOAD_VEC, POP_FLAGS, POP_LO, POP_HI, RESUME
  } state_t;
  state_t        state_q, state_d;
  logic          int_q, pending_q, pending_d, accept;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   saved_pc_q, saved_pc_d;
  logic [2:0]    saved_flags_q, saved_flags_d, flags_q, flags_d;
  logic [15:0]   pc_lo_q, pc_lo_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      int_q         <= 1'b0;
      pending_q     <= 1'b0;
      cnt_q         <= '0;
      saved_pc_q    <= '0;
      saved_flags_q <= '0;
      flags_q       <= '0;
      pc_lo_q       <= '0;
    end else begin
      state_q       <= state_d;
      int_q         <= INT;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      saved_pc_q    <= saved_pc_d;
      saved_flags_q <= saved_flags_d;
      flags_q       <= flags_d;
      pc_lo_q       <= pc_lo_d;
    end
  end
  // The request is consumed at acceptance, so any edge seen during service queues another one
  // that is picked up once LOAD_VEC returns to IDLE.
  assign accept    = state_q == IDLE && !RTI_Req && pending_q && !Taken_Jump;
  assign pending_d = (INT & ~int_q) | (pending_q & ~accept);
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    saved_pc_d    = saved_pc_q;
    saved_flags_d = saved_flags_q;
    flags_d       = flags_q;
    pc_lo_d       = pc_lo_q;
    Stall         = 1'b0;
    Flush         = 1'b0;
    Mem_Write     = 1'b0;
    Mem_Read      = 1'b0;
    Mem_Data_Out  = '0;
    PC_Load       = 1'b0;
    PC_Out        = '0;
    Flags_Load    = 1'b0;
    Flags_Out     = '0;
    INT_Ack       = 1'b0;
    Busy          = state_q != IDLE;
    unique case (state_q)
      IDLE: begin
        if (RTI_Req) state_d = POP_FLAGS;
        else if (accept) begin
          state_d       = DRAIN;
          cnt_d         = CW'(DRAIN_CYCLES - 1);
          saved_pc_d    = PC_In;
          saved_flags_d = Flags_In;
        end
      end
      DRAIN: begin
        Stall   = 1'b1;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        state_d = cnt_q == '0 ? PUSH_HI : DRAIN;
      end
      PUSH_HI: begin
        Stall        = 1'b1;
        Mem_Write    = 1'b1;
        Mem_Data_Out = saved_pc_q[31:16];
        state_d      = PUSH_LO;
      end
      PUSH_LO: begin
        Stall        = 1'b1;
        Mem_Write    = 1'b1;
        Mem_Data_Out = saved_pc_q[15:0];
        state_d      = PUSH_FL;
      end
      PUSH_FL: begin
        Stall        = 1'b1;
        Mem_Write    = 1'b1;
        Mem_Data_Out = {13'b0, saved_flags_q};
        state_d      = LOAD_VEC;
      end
      LOAD_VEC: begin
        PC_Load = 1'b1;
        PC_Out  = VECTOR_ADDR;
        Flush   = 1'b1;
        INT_Ack = 1'b1;
        state_d = IDLE;
      end
      POP_FLAGS: begin
        Stall    = 1'b1;
        Flush    = 1'b1;
        Mem_Read = 1'b1;
        state_d  = POP_LO;
      end
      POP_LO: begin
        Stall    = 1'b1;
        Mem_Read = 1'b1;
        flags_d  = Mem_Data_In[2:0];
        state_d  = POP_HI;
      end
      POP_HI: begin
        Stall    = 1'b1;
        Mem_Read = 1'b1;
        pc_lo_d  = Mem_Data_In;
        state_d  = RESUME;
      end
      RESUME: begin
        PC_Load    = 1'b1;
        PC_Out     = {Mem_Data_In, pc_lo_q};
        Flags_Load = 1'b1;
        Flags_Out  = flags_q;
        Flush      = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: table-driven per-cycle vectors through a scoreboard queue, plus latency sequences.
module tb_interrupt_sequencer;
  typedef struct packed {
    logic        stall, flush, mwr, mrd;
    logic [15:0] mdo;
    logic        pcl;
    logic [31:0] pco;
    logic        fll;
    logic [2:0]  flo;
    logic        ack, busy;
  } out_t;
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] pc;
    logic [2:0]  fl;
    logic [15:0] md;
    out_t        e;
    string       name;
  } vec_t;
  logic        clk = 1'b0, rst, INT, RTI_Req, Taken_Jump;
  logic [31:0] PC_In;
  logic [2:0]  Flags_In;
  logic [15:0] Mem_Data_In;
  logic        Stall, Flush, Mem_Write, Mem_Read, PC_Load, Flags_Load, INT_Ack, Busy;
  logic [15:0] Mem_Data_Out;
  logic [31:0] PC_Out;
  logic [2:0]  Flags_Out;
  out_t        act;
  vec_t        tbl[$];
  vec_t        sb[$];
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .INT(INT), .RTI_Req(RTI_Req), .Taken_Jump(Taken_Jump),
    .PC_In(PC_In), .Flags_In(Flags_In), .Mem_Data_In(Mem_Data_In),
    .Stall(Stall), .Flush(Flush), .Mem_Write(Mem_Write), .Mem_Read(Mem_Read),
    .Mem_Data_Out(Mem_Data_Out), .PC_Load(PC_Load), .PC_Out(PC_Out),
    .Flags_Load(Flags_Load), .Flags_Out(Flags_Out), .INT_Ack(INT_Ack), .Busy(Busy)
  );
  assign act = {Stall, Flush, Mem_Write, Mem_Read, Mem_Data_Out, PC_Load, PC_Out,
                Flags_Load, Flags_Out, INT_Ack, Busy};
  function automatic out_t o_idle();
    out_t r = '0;
    return r;
  endfunction
  function automatic out_t o_drain();
    out_t r = '0;
    r.stall = 1'b1; r.busy = 1'b1;
    return r;
  endfunction
  function automatic out_t o_push(input logic [15:0] d);
    out_t r = '0;
    r.stall = 1'b1; r.mwr = 1'b1; r.mdo = d; r.busy = 1'b1;
    return r;
  endfunction
  function automatic out_t o_load();
    out_t r = '0;
    r.pcl = 1'b1; r.pco = 32'h0000_0002; r.flush = 1'b1; r.ack = 1'b1; r.busy = 1'b1;
    return r;
  endfunction
  function automatic out_t o_popf();
    out_t r = '0;
    r.stall = 1'b1; r.flush = 1'b1; r.mrd = 1'b1; r.busy = 1'b1;
    return r;
  endfunction
  function automatic out_t o_pop();
    out_t r = '0;
    r.stall = 1'b1; r.mrd = 1'b1; r.busy = 1'b1;
    return r;
  endfunction
  function automatic out_t o_res(input logic [31:0] pc, input logic [2:0] f);
    out_t r = '0;
    r.pcl = 1'b1; r.pco = pc; r.fll = 1'b1; r.flo = f; r.flush = 1'b1; r.busy = 1'b1;
    return r;
  endfunction
  // ctl = {rst, INT, RTI_Req, Taken_Jump}
  task automatic add(input logic [3:0] c, input logic [31:0] pc, input logic [2:0] f,
                     input logic [15:0] md, input out_t e, input string n);
    vec_t v;
    v.ctl = c; v.pc = pc; v.fl = f; v.md = md; v.e = e; v.name = n;
    tbl.push_back(v);
  endtask
  task automatic drains(input logic [3:0] c, input logic [31:0] pc, input string n);
    for (int i = 0; i < 3; i++) add(c, pc, 3'd0, 16'h0, o_drain(), n);
  endtask
  task automatic chk(input vec_t v);
    n_vec++;
    if (act !== v.e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", v.name, act, v.e);
    end
  endtask
  task automatic chk_val(input string n, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", n, got, want);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    rst = 1'b1; INT = 1'b0; RTI_Req = 1'b0; Taken_Jump = 1'b0;
    PC_In = '0; Flags_In = '0; Mem_Data_In = '0;
    // interrupt entry
    add(4'b0000, 32'h0001_2345, 3'd5, 16'h0, o_idle(), "reset_state");
    add(4'b0100, 32'h0001_2345, 3'd5, 16'h0, o_idle(), "int_edge");
    add(4'b0000, 32'h0001_2345, 3'd5, 16'h0, o_idle(), "int_accept");
    drains(4'b0000, 32'h0001_2345, "int_drain");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_push(16'h0001), "push_hi");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_push(16'h2345), "push_lo");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_push(16'h0005), "push_fl");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_load(), "load_vec");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_idle(), "int_done");
    // return
    add(4'b0010, 32'h0, 3'd0, 16'hFFFF, o_idle(), "rti_req");
    add(4'b0000, 32'h0, 3'd0, 16'hFFFF, o_popf(), "pop_flags");
    add(4'b0000, 32'h0, 3'd0, 16'h0005, o_pop(), "pop_lo");
    add(4'b0000, 32'h0, 3'd0, 16'h2345, o_pop(), "pop_hi");
    add(4'b0000, 32'h0, 3'd0, 16'h0001, o_res(32'h0001_2345, 3'b101), "resume");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_idle(), "rti_done");
    // pending held off by a taken jump
    add(4'b0101, 32'h0000_0030, 3'd2, 16'h0, o_idle(), "tj_edge");
    add(4'b0001, 32'h0000_0030, 3'd2, 16'h0, o_idle(), "tj_wait");
    add(4'b0000, 32'h0000_0040, 3'd2, 16'h0, o_idle(), "tj_accept");
    drains(4'b0000, 32'h0, "tj_drain");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_push(16'h0000), "tj_push_hi");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_push(16'h0040), "tj_push_lo");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_push(16'h0002), "tj_push_fl");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_load(), "tj_load");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_idle(), "tj_done");
    // RTI wins over a pending interrupt
    add(4'b0100, 32'h0000_1000, 3'd1, 16'h0, o_idle(), "pri_edge");
    add(4'b0010, 32'h0000_1000, 3'd1, 16'h0, o_idle(), "pri_rti");
    add(4'b0000, 32'h0000_1000, 3'd1, 16'h0, o_popf(), "pri_pop_flags");
    add(4'b0000, 32'h0000_1000, 3'd1, 16'h0006, o_pop(), "pri_pop_lo");
    add(4'b0000, 32'h0000_1000, 3'd1, 16'h5678, o_pop(), "pri_pop_hi");
    add(4'b0000, 32'h0000_1000, 3'd1, 16'h0009, o_res(32'h0009_5678, 3'b110), "pri_resume");
    add(4'b0000, 32'h0000_1000, 3'd1, 16'h0, o_idle(), "pri_accept");
    drains(4'b0000, 32'h0, "pri_drain");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_push(16'h0000), "pri_push_hi");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_push(16'h1000), "pri_push_lo");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_push(16'h0001), "pri_push_fl");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_load(), "pri_load");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_idle(), "pri_done");
    // second edge during PUSH_LO, then INT held high
    add(4'b0100, 32'h0ABC_0010, 3'd3, 16'h0, o_idle(), "re_edge");
    add(4'b0100, 32'h0ABC_0010, 3'd3, 16'h0, o_idle(), "re_accept");
    drains(4'b0000, 32'h0, "re_drain");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_push(16'h0ABC), "re_push_hi");
    add(4'b0100, 32'h0, 3'd0, 16'h0, o_push(16'h0010), "re_push_lo");
    add(4'b0100, 32'h0, 3'd0, 16'h0, o_push(16'h0003), "re_push_fl");
    add(4'b0100, 32'h0, 3'd0, 16'h0, o_load(), "re_load");
    add(4'b0100, 32'h0000_0200, 3'd0, 16'h0, o_idle(), "re2_accept");
    drains(4'b0100, 32'h0, "re2_drain");
    add(4'b0100, 32'h0, 3'd0, 16'h0, o_push(16'h0000), "re2_push_hi");
    add(4'b0100, 32'h0, 3'd0, 16'h0, o_push(16'h0200), "re2_push_lo");
    add(4'b0100, 32'h0, 3'd0, 16'h0, o_push(16'h0000), "re2_push_fl");
    add(4'b0100, 32'h0, 3'd0, 16'h0, o_load(), "re2_load");
    add(4'b0100, 32'h0, 3'd0, 16'h0, o_idle(), "held_idle1");
    add(4'b0100, 32'h0, 3'd0, 16'h0, o_idle(), "held_idle2");
    add(4'b0100, 32'h0, 3'd0, 16'h0, o_idle(), "held_idle3");
    // reset in PUSH_LO
    add(4'b0000, 32'h0777_0888, 3'd7, 16'h0, o_idle(), "rst_low");
    add(4'b0100, 32'h0777_0888, 3'd7, 16'h0, o_idle(), "rst_edge");
    add(4'b0000, 32'h0777_0888, 3'd7, 16'h0, o_idle(), "rst_accept");
    drains(4'b0000, 32'h0, "rst_drain");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_push(16'h0777), "rst_push_hi");
    add(4'b1000, 32'h0, 3'd0, 16'h0, o_push(16'h0888), "rst_push_lo");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_idle(), "rst_after");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_idle(), "rst_no_pending1");
    add(4'b0000, 32'h0, 3'd0, 16'h0, o_idle(), "rst_no_pending2");
    repeat (2) @(posedge clk);
    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk);
      #1;
      {rst, INT, RTI_Req, Taken_Jump} = tbl[k].ctl;
      PC_In = tbl[k].pc; Flags_In = tbl[k].fl; Mem_Data_In = tbl[k].md;
      sb.push_back(tbl[k]);
      @(negedge clk);
      chk(sb.pop_front());
    end
    // interrupt latency: acceptance cycle to PC_Load
    @(posedge clk); #1; {rst, INT, RTI_Req, Taken_Jump} = 4'b0100;
    @(posedge clk); #1; INT = 1'b0;
    lat = 0;
    while (!PC_Load && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    chk_val("int_latency", lat, 7);
    @(posedge clk); #1;
    chk_val("int_busy_after", int'(Busy), 0);
    // RTI latency: RTI_Req cycle to PC_Load
    RTI_Req = 1'b1; Mem_Data_In = 16'h0003;
    lat = 0;
    do begin
      @(posedge clk); #1; RTI_Req = 1'b0; lat++;
    end while (!PC_Load && lat < 30);
    chk_val("rti_latency", lat, 4);
    chk_val("rti_flags_load", int'(Flags_Load), 1);
    @(posedge clk); #1;
    chk_val("rti_busy_after", int'(Busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
